// File: rtl/data_addr_demux_pkg.sv
// Shared bus definitions for the data-side address demultiplexer:
// slave indices, default address windows and target-index sizing.
package data_addr_demux_pkg;

    typedef enum logic [2:0] {
        SLV_RAM   = 3'd0,
        SLV_IO    = 3'd1,
        SLV_UART0 = 3'd2,
        SLV_TM0   = 3'd3,
        SLV_TM1   = 3'd4
    } slv_idx_e;

    localparam int DEF_NUM_SLV = 5;

    localparam logic [31:0] ADDR_BASE_RAM   = 32'h0000_0000;
    localparam logic [31:0] ADDR_BASE_IO    = 32'h0002_0000;
    localparam logic [31:0] ADDR_BASE_UART0 = 32'h0003_0000;
    localparam logic [31:0] ADDR_BASE_TM0   = 32'h0004_0000;
    localparam logic [31:0] ADDR_BASE_TM1   = 32'h0004_1000;

    localparam logic [31:0] ADDR_MASK_RAM    = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_MASK_PERIPH = 32'hFFFF_F000;

    // Packed tables are listed MSB first, so element [0] is the RAM window.
    localparam logic [DEF_NUM_SLV-1:0][31:0] DEF_SLV_BASE = {
        ADDR_BASE_TM1, ADDR_BASE_TM0, ADDR_BASE_UART0, ADDR_BASE_IO, ADDR_BASE_RAM
    };
    localparam logic [DEF_NUM_SLV-1:0][31:0] DEF_SLV_MASK = {
        ADDR_MASK_PERIPH, ADDR_MASK_PERIPH, ADDR_MASK_PERIPH, ADDR_MASK_PERIPH, ADDR_MASK_RAM
    };

    // The extra code point NUM_SLV names the internal error target.
    function automatic int tgt_width(input int num_slv);
        return (num_slv < 1) ? 1 : $clog2(num_slv + 1);
    endfunction

    localparam int DEF_TGT_W = tgt_width(DEF_NUM_SLV);
    typedef logic [DEF_TGT_W-1:0] tgt_t;

endpackage

// File: rtl/data_addr_demux_if.sv
// Bus bundle between the LSU data port, the demultiplexer and its slaves.
// 'slave' is the demultiplexer's view; 'master' is the surrounding system's view.
interface data_addr_demux_if #(
    parameter int NUM_SLV = 5,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic                             m_req;
    logic                             m_we;
    logic [DATA_W/8-1:0]              m_be;
    logic [ADDR_W-1:0]                m_addr;
    logic [DATA_W-1:0]                m_wdata;
    logic                             m_gnt;
    logic                             m_rvalid;
    logic [DATA_W-1:0]                m_rdata;
    logic                             m_err;

    logic [NUM_SLV-1:0]               s_req;
    logic                             s_we;
    logic [DATA_W/8-1:0]              s_be;
    logic [ADDR_W-1:0]                s_addr;
    logic [DATA_W-1:0]                s_wdata;
    logic [NUM_SLV-1:0]               s_gnt;
    logic [NUM_SLV-1:0]               s_rvalid;
    logic [NUM_SLV-1:0][DATA_W-1:0]   s_rdata;
    logic [NUM_SLV-1:0]               s_err;

    modport slave (
        input  m_req, m_we, m_be, m_addr, m_wdata,
        output m_gnt, m_rvalid, m_rdata, m_err,
        output s_req, s_we, s_be, s_addr, s_wdata,
        input  s_gnt, s_rvalid, s_rdata, s_err
    );

    modport master (
        output m_req, m_we, m_be, m_addr, m_wdata,
        input  m_gnt, m_rvalid, m_rdata, m_err,
        input  s_req, s_we, s_be, s_addr, s_wdata,
        output s_gnt, s_rvalid, s_rdata, s_err
    );

endinterface

// File: rtl/data_addr_demux_err_slave.sv
// Internal responder for unmapped accesses: one error beat, rdata zero,
// exactly one cycle after each accepted request.
module data_addr_demux_err_slave #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    output logic              rvalid_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic rvalid_q;
    logic rvalid_d;

    assign rvalid_d = req_i;

    // Single-entry pipeline stage; a new request may enter while the previous beat leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = rvalid_q;
    assign rdata_o  = {DATA_W{1'b0}};

endmodule

// File: rtl/data_addr_demux.sv
// Data-side address demultiplexer: BASE/MASK decode, same-target ordering of
// outstanding transactions, internal error target and a sticky response watchdog.
module data_addr_demux
    import data_addr_demux_pkg::*;
#(
    parameter int NUM_SLV     = 5,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_OUT     = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter logic [NUM_SLV-1:0][ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLV-1:0][ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK
) (
    input  logic                clk,
    input  logic                rst_n,
    data_addr_demux_if.slave    bus,
    input  logic                timeout_clr,
    output logic                timeout_o
);

    localparam int TGT_W = tgt_width(NUM_SLV);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [TGT_W-1:0] ERR_TGT = TGT_W'(NUM_SLV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYC);
    localparam logic [WD_W-1:0]  WD_FIRE = WD_W'(TIMEOUT_CYC - 1);

    logic [NUM_SLV-1:0] hit_s;
    logic [TGT_W-1:0]   tgt_s;
    logic               err_sel_s;
    logic               cnt_zero_s;
    logic               accept_s;
    logic               slv_gnt_s;
    logic               gnt_s;
    logic               hs_s;

    logic               err_rvalid_s;
    logic               err_err_s;
    logic [DATA_W-1:0]  err_rdata_s;

    logic               rsp_valid_s;
    logic [DATA_W-1:0]  rsp_data_s;
    logic               rsp_err_s;
    logic               rsp_fire_s;
    logic               wd_fire_s;

    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [TGT_W-1:0]   cur_tgt_q, cur_tgt_d;
    logic [WD_W-1:0]    wd_q,      wd_d;
    logic               timeout_q, timeout_d;

    for (genvar g = 0; g < NUM_SLV; g++) begin : g_hit
        assign hit_s[g] = ((bus.m_addr & SLV_MASK[g]) == SLV_BASE[g]);
    end

    // Priority decode: scanning downwards lets the lowest matching index win.
    always_comb begin
        tgt_s = ERR_TGT;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            tgt_s = hit_s[i] ? TGT_W'(i) : tgt_s;
        end
    end

    assign err_sel_s  = (tgt_s == ERR_TGT);
    assign cnt_zero_s = (cnt_q == {CNT_W{1'b0}});
    assign accept_s   = (cnt_q < CNT_MAX) && (cnt_zero_s || (tgt_s == cur_tgt_q));

    // Route the request to the decoded slave and pick up its grant.
    always_comb begin
        slv_gnt_s = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            bus.s_req[i] = bus.m_req & accept_s & (tgt_s == TGT_W'(i));
            slv_gnt_s    = (tgt_s == TGT_W'(i)) ? bus.s_gnt[i] : slv_gnt_s;
        end
    end

    assign gnt_s     = bus.m_req & accept_s & (err_sel_s | slv_gnt_s);
    assign hs_s      = bus.m_req & gnt_s;
    assign bus.m_gnt = gnt_s;

    assign bus.s_we    = bus.m_we;
    assign bus.s_be    = bus.m_be;
    assign bus.s_addr  = bus.m_addr;
    assign bus.s_wdata = bus.m_wdata;

    data_addr_demux_err_slave #(
        .DATA_W (DATA_W)
    ) u_err_slave (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (hs_s & err_sel_s),
        .rvalid_o (err_rvalid_s),
        .err_o    (err_err_s),
        .rdata_o  (err_rdata_s)
    );

    // Response select follows the registered target, so only that slave is listened to.
    always_comb begin
        rsp_valid_s = err_rvalid_s;
        rsp_data_s  = err_rdata_s;
        rsp_err_s   = err_err_s;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (cur_tgt_q == TGT_W'(i)) begin
                rsp_valid_s = bus.s_rvalid[i];
                rsp_data_s  = bus.s_rdata[i];
                rsp_err_s   = bus.s_err[i];
            end else begin
                rsp_valid_s = rsp_valid_s;
                rsp_data_s  = rsp_data_s;
                rsp_err_s   = rsp_err_s;
            end
        end
    end

    assign rsp_fire_s   = rsp_valid_s & ~cnt_zero_s;
    assign bus.m_rvalid = rsp_fire_s;
    assign bus.m_rdata  = rsp_fire_s ? rsp_data_s : {DATA_W{1'b0}};
    assign bus.m_err    = rsp_fire_s & rsp_err_s;

    // Next state for the outstanding tracker and the watchdog.
    always_comb begin
        case ({hs_s, rsp_fire_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        cur_tgt_d = hs_s ? tgt_s : cur_tgt_q;

        if (cnt_zero_s || rsp_fire_s) begin
            wd_d = {WD_W{1'b0}};
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WD_W'(1);
        end else begin
            wd_d = wd_q;
        end

        // Fire only on the step into the limit so a clear is not immediately overridden.
        wd_fire_s = ~cnt_zero_s & ~rsp_fire_s & (wd_q == WD_FIRE);

        if (wd_fire_s) begin
            timeout_d = 1'b1;
        end else if (timeout_clr) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Tracker, target latch, watchdog and sticky timeout state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= {CNT_W{1'b0}};
            cur_tgt_q <= {TGT_W{1'b0}};
            wd_q      <= {WD_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cur_tgt_q <= cur_tgt_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule
